// File: rtl/core_inv_if.sv
// core_inv_if: valid/ready request and response bundle for core_inv.
interface core_inv_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_res;
  logic [2:0] in_n1;
  logic       opt;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_n0;
  logic       out_err;
  modport slave (
    input  in_valid, in_res, in_n1, opt, out_ready,
    output in_ready, out_valid, out_n0, out_err
  );
  modport master (
    output in_valid, in_res, in_n1, opt, out_ready,
    input  in_ready, out_valid, out_n0, out_err
  );
endinterface

// File: rtl/core_inv.sv
// core_inv: bit-serial recovery of n0 from an add/subtract result, one full-adder step per clock.
module core_inv (
  input logic       clk,
  input logic       rst,
  core_inv_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic [3:0] res_q, res_d;
  logic [3:0] b_q, b_d;
  logic [3:0] sum_q, sum_d;
  logic       fa_s, fa_c;
  assign fa_s = res_q[cnt_q] ^ b_q[cnt_q] ^ carry_q;
  assign fa_c = (res_q[cnt_q] & b_q[cnt_q]) | (carry_q & (res_q[cnt_q] ^ b_q[cnt_q]));
  // Subtraction of n1 is folded into the operand latch as ~n1 with carry-in 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    res_d   = res_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        res_d   = bus.in_res;
        b_d     = bus.opt ? {1'b0, bus.in_n1} : ~{1'b0, bus.in_n1};
        carry_d = ~bus.opt;
        cnt_d   = 2'd0;
        state_d = CALC;
      end
      CALC: begin
        sum_d[cnt_q] = fa_s;
        carry_d      = fa_c;
        cnt_d        = cnt_q + 2'd1;
        state_d      = (cnt_q == 2'd3) ? DONE : CALC;
      end
      DONE:    state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.out_n0    = bus.out_valid ? sum_q[2:0] : 3'd0;
  assign bus.out_err   = bus.out_valid & sum_q[3];
endmodule

// File: tb/tb_core_inv.sv
// tb_core_inv: scoreboard bench for core_inv; driver queues expectations, monitor checks on handshake.
module tb_core_inv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rnd_rdy = 1'b0;
  typedef struct {
    int n0;
    int err;
    int acc;
  } exp_t;
  exp_t sb[$];
  core_inv_if bus();
  core_inv dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic send(input int r, input int n, input int o, input int en0, input int ee);
    int t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_res   = 4'(r);
    bus.in_n1    = 3'(n);
    bus.opt      = 1'(o);
    sb.push_back('{en0, ee, cyc + 1});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_res   = 4'($urandom);
    bus.in_n1    = 3'($urandom);
    bus.opt      = 1'($urandom);
  endtask
  task automatic wait_valid();
    int t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("valid_timeout", int'(bus.out_valid), 1);
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask
  initial begin : monitor
    bit pv = 1'b0;
    int h_n0 = 0;
    int h_err = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        pv = 1'b0;
        continue;
      end
      if (bus.out_valid) begin
        if (!pv) begin
          h_n0  = int'(bus.out_n0);
          h_err = int'(bus.out_err);
          if (sb.size() == 0) chk("unexpected_output", 1, 0);
          else chk("latency", cyc - sb[0].acc, 4);
        end else begin
          chk("hold_n0", int'(bus.out_n0), h_n0);
          chk("hold_err", int'(bus.out_err), h_err);
        end
        chk("in_ready_in_done", int'(bus.in_ready), 0);
        if (bus.out_ready && sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_n0", int'(bus.out_n0), e.n0);
          chk("out_err", int'(bus.out_err), e.err);
        end
      end
      pv = bus.out_valid;
    end
  end
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_res    = '0;
    bus.in_n1     = '0;
    bus.opt       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_n0", int'(bus.out_n0), 0);
    rst = 1'b0;
    send(9, 3, 0, 6, 0);
    send(14, 5, 1, 3, 0);
    send(15, 0, 0, 7, 1);
    send(8, 7, 1, 7, 1);
    drain();
    // Backpressure: outputs frozen, no acceptance while held in DONE.
    bus.out_ready = 1'b0;
    send(6, 2, 0, 4, 0);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'(i != 1);
      bus.in_res   = 4'($urandom);
      @(negedge clk);
      chk("bp_valid", int'(bus.out_valid), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(bus.out_valid), 0);
    chk("bp_release_ready", int'(bus.in_ready), 1);
    chk("bp_no_extra", sb.size(), 0);
    // Asynchronous reset in the middle of a cycle while in DONE.
    bus.out_ready = 1'b0;
    send(15, 0, 0, 7, 1);
    wait_valid();
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", int'(bus.in_ready), 1);
    chk("arst_out_valid", int'(bus.out_valid), 0);
    chk("arst_out_n0", int'(bus.out_n0), 0);
    chk("arst_out_err", int'(bus.out_err), 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    // Reset after the second serial step aborts the pair.
    send(9, 3, 0, 6, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #2;
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    send(0, 0, 1, 0, 0);
    drain();
    rnd_rdy = 1'b1;
    for (int o = 0; o < 2; o++)
      for (int n0 = 0; n0 < 8; n0++)
        for (int n1 = 0; n1 < 8; n1++) begin
          repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
          end
          send((o != 0 ? n0 - n1 : n0 + n1) & 15, n1, o, n0, 0);
        end
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
